// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction ROM
// and buffers fetched words with their PCs in a small FIFO towards issue.
module inst_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          ROM_BYTES = 100,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     rom_nrd,
  output logic [31:0]              rom_addr,
  input  logic [31:0]              rom_data,
  output logic                     iq_valid,
  output logic [31:0]              iq_inst,
  output logic [31:0]              iq_pc,
  input  logic                     iq_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fetch_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic [32:0]   pc_end;
  logic          in_range;
  logic          full;
  logic          pop;
  logic          fetch_en;

  // End-of-ROM check is done in 33 bits so a PC near 2^32 cannot wrap into range.
  assign pc_end   = {1'b0, pc} + 33'd4;
  assign in_range = (pc_end <= 33'(ROM_BYTES));
  assign full     = (cnt == CW'(DEPTH));
  assign iq_valid = (cnt != '0);
  assign pop      = iq_valid & iq_ready;

  // A full queue may still fetch when its head leaves in the same cycle.
  assign fetch_en = rst_n & ~redirect & in_range & (~full | pop);

  assign rom_nrd    = ~fetch_en;
  assign rom_addr   = pc;
  assign count      = cnt;
  assign fetch_done = ~in_range & ~iq_valid;

  // Storage is not reset, so the head is masked to read zero when empty.
  assign iq_inst = iq_valid ? mem_inst[rd_ptr] : 32'h0;
  assign iq_pc   = iq_valid ? mem_pc[rd_ptr]   : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (fetch_en) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fetch_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_en) begin
      mem_inst[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a byte-addressed ROM model.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic        fetch_done;

  int n_checks;
  int n_pass;
  int exp_pc;

  inst_fetch_queue #(.DEPTH(4), .ROM_BYTES(100), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_nrd    (rom_nrd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .iq_valid   (iq_valid),
    .iq_inst    (iq_inst),
    .iq_pc      (iq_pc),
    .iq_ready   (iq_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .count      (count),
    .fetch_done (fetch_done)
  );

  function automatic logic [31:0] romword(input logic [31:0] a);
    if (a == 32'd0)      return 32'h2001_0005;
    else if (a == 32'd4) return 32'h8C22_0004;
    else                 return {16'hC0DE, a[15:0]};
  endfunction

  always_comb rom_data = romword(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    iq_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    #2;
    check("rst_nrd",   32'(rom_nrd),  32'd1);
    check("rst_valid", 32'(iq_valid), 32'd0);
    check("rst_count", 32'(count),    32'd0);
    check("rst_inst",  iq_inst,       32'h0);
    check("rst_pc",    iq_pc,         32'h0);
    check("rst_addr",  rom_addr,      32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("c1_nrd",  32'(rom_nrd), 32'd0);
    check("c1_addr", rom_addr,     32'h0);
    tick();
    check("c2_valid", 32'(iq_valid), 32'd1);
    check("c2_inst",  iq_inst,       32'h2001_0005);
    check("c2_pc",    iq_pc,         32'h0);
    check("c2_addr",  rom_addr,      32'd4);
    tick();
    tick();
    tick();
    check("full_count", 32'(count), 32'd4);
    check("full_nrd",   32'(rom_nrd), 32'd1);
    check("full_addr",  rom_addr,   32'd16);
    tick();
    tick();
    check("hold_count", 32'(count), 32'd4);
    check("hold_addr",  rom_addr,   32'd16);
    check("hold_pc",    iq_pc,      32'h0);
    check("hold_inst",  iq_inst,    32'h2001_0005);

    // Pop while full: a fetch must happen in the same cycle.
    iq_ready = 1'b1;
    #1;
    check("fullpop_nrd", 32'(rom_nrd), 32'd0);
    tick();
    iq_ready = 1'b0;
    #1;
    check("fullpop_count", 32'(count), 32'd4);
    check("fullpop_pc",    iq_pc,      32'd4);
    check("fullpop_inst",  iq_inst,    32'h8C22_0004);
    check("fullpop_addr",  rom_addr,   32'd20);

    // Stream to the end of the ROM.
    iq_ready = 1'b1;
    exp_pc   = 4;
    for (int i = 0; i < 60 && exp_pc < 100; i++) begin
      if (iq_valid) begin
        check("stream_pc",   iq_pc,   32'(exp_pc));
        check("stream_inst", iq_inst, romword(32'(exp_pc)));
        if (exp_pc == 96) check("stream_done_early", 32'(fetch_done), 32'd0);
        exp_pc += 4;
      end
      tick();
    end
    check("stream_last",  32'(exp_pc),     32'd100);
    check("end_done",     32'(fetch_done), 32'd1);
    check("end_addr",     rom_addr,        32'd100);
    check("end_nrd",      32'(rom_nrd),    32'd1);
    check("end_valid",    32'(iq_valid),   32'd0);
    iq_ready = 1'b0;

    // Refill with PCs 8..20, then redirect to 0x42.
    redirect    = 1'b1;
    redirect_pc = 32'd8;
    #1;
    check("redir_nrd", 32'(rom_nrd), 32'd1);
    tick();
    redirect = 1'b0;
    #1;
    check("refill_addr", rom_addr,        32'd8);
    check("refill_done", 32'(fetch_done), 32'd0);
    tick();
    tick();
    tick();
    tick();
    check("refill_count", 32'(count), 32'd4);
    check("refill_pc",    iq_pc,      32'd8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0042;
    tick();
    redirect = 1'b0;
    #1;
    check("r42_count", 32'(count),    32'd0);
    check("r42_valid", 32'(iq_valid), 32'd0);
    check("r42_addr",  rom_addr,      32'h40);
    tick();
    check("r42_pc",    iq_pc,   32'h40);
    check("r42_inst",  iq_inst, romword(32'h40));
    tick();
    tick();
    check("pre_rst_count", 32'(count), 32'd3);

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(iq_valid), 32'd0);
    check("arst_count", 32'(count),    32'd0);
    check("arst_nrd",   32'(rom_nrd),  32'd1);
    check("arst_addr",  rom_addr,      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_nrd",  32'(rom_nrd), 32'd0);
    check("rel_addr", rom_addr,     32'd0);
    tick();
    check("rel_pc",   iq_pc,   32'd0);
    check("rel_inst", iq_inst, 32'h2001_0005);

    // A PC near 2^32 must be out of range, not wrap into it.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_addr", rom_addr,        32'hFFFF_FFFC);
    check("wrap_nrd",  32'(rom_nrd),    32'd1);
    check("wrap_done", 32'(fetch_done), 32'd1);

    // Last legal word, then fetch_done after draining it.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0061;
    tick();
    redirect = 1'b0;
    #1;
    check("last_done0", 32'(fetch_done), 32'd0);
    check("last_nrd",   32'(rom_nrd),    32'd0);
    check("last_addr",  rom_addr,        32'h60);
    tick();
    check("last_count", 32'(count),      32'd1);
    check("last_addr2", rom_addr,        32'd100);
    check("last_pc",    iq_pc,           32'h60);
    check("last_done1", 32'(fetch_done), 32'd0);
    iq_ready = 1'b1;
    tick();
    check("last_done2", 32'(fetch_done), 32'd1);
    check("last_valid", 32'(iq_valid),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
